// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and helpers for pin-facing input blocks.
// Holds the default debounce length, counter sizing and sync depth.
package gpio_pkg;

  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int SYNC_STAGES      = 2;

  // Counter width able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one-bit synchronizer, stability counter and edge pulses.
// A new level is accepted after DEBOUNCE_CYCLES differing samples.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_set_o,
  output logic fall_set_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s2;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   rise_q;
  logic                   fall_q;
  logic                   accept;

  assign s2 = sync_q[SYNC_STAGES-1];

  // Shift the raw pin into the sysclk domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  // Count consecutive samples disagreeing with the stable level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (s2 == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      accept   = 1'b1;
      stable_d = s2;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_set_o = accept & s2;
  assign fall_set_o = accept & ~s2;

  // Stable level, counter and registered edge pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_set_o;
      fall_q   <= fall_set_o;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: debounced GPIO inputs with edge pulses and flags.
// Pending flags are sticky; a set on the same edge beats a clear.
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_pins_in,
  output logic [WIDTH-1:0] io_gpio_in,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic [WIDTH-1:0] io_edge_pending,
  input  logic [WIDTH-1:0] io_clear,
  output logic             io_any_pending
);

  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock     (clock),
      .reset     (reset),
      .pin_i     (io_pins_in[g]),
      .level_o   (io_gpio_in[g]),
      .rise_o    (io_rise[g]),
      .fall_o    (io_fall[g]),
      .rise_set_o(rise_set[g]),
      .fall_set_o(fall_set[g])
    );
  end

  // Clear masked flags, then set any freshly accepted edge.
  always_comb begin
    pending_d = (pending_q & ~io_clear) | rise_set | fall_set;
  end

  // Sticky per-bit edge flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign io_edge_pending = pending_q;
  assign io_any_pending  = |pending_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: directed plus random checks against a window model.
// Model accepts a level once the last D synced samples all differ.
module tb_gpio_in_debounce;

  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] io_pins_in;
  logic [W-1:0] io_clear;
  logic [W-1:0] io_gpio_in;
  logic [W-1:0] io_rise;
  logic [W-1:0] io_fall;
  logic [W-1:0] io_edge_pending;
  logic         io_any_pending;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] hist[$];
  logic [W-1:0] win[D];
  logic [W-1:0] m_stable;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic [W-1:0] m_pend;

  gpio_in_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_pins_in     (io_pins_in),
    .io_gpio_in     (io_gpio_in),
    .io_rise        (io_rise),
    .io_fall        (io_fall),
    .io_edge_pending(io_edge_pending),
    .io_clear       (io_clear),
    .io_any_pending (io_any_pending)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < D; k++) win[k] = '0;
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_pend   = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] pins,
                            input logic [W-1:0] clr);
    logic [W-1:0] samp;
    logic         diff;
    samp = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    hist.push_back(pins);
    if (hist.size() > 2) void'(hist.pop_front());
    for (int k = 0; k < D-1; k++) win[k] = win[k+1];
    win[D-1] = samp;
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < W; b++) begin
      diff = 1'b1;
      for (int k = 0; k < D; k++)
        if (win[k][b] == m_stable[b]) diff = 1'b0;
      if (diff) begin
        if (m_stable[b]) m_fall[b] = 1'b1;
        else             m_rise[b] = 1'b1;
        m_stable[b] = ~m_stable[b];
      end
    end
    m_pend = (m_pend & ~clr) | m_rise | m_fall;
  endtask

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check("gpio", io_gpio_in, m_stable);
    check("rise", io_rise, m_rise);
    check("fall", io_fall, m_fall);
    check("pending", io_edge_pending, m_pend);
    check("any", {7'b0, io_any_pending}, {7'b0, |m_pend});
  endtask

  task automatic step(input logic [W-1:0] pins,
                      input logic [W-1:0] clr);
    io_pins_in = pins;
    io_clear   = clr;
    @(posedge clock);
    model_edge(pins, clr);
    #1;
    check_model();
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_model();
  endtask

  task automatic release_reset(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] p;
    logic [W-1:0] c;
    io_pins_in = '0;
    io_clear   = '0;
    assert_reset();
    release_reset(2);

    for (int i = 0; i < 20; i++) step(8'h00, 8'h00);

    for (int i = 1; i <= 8; i++) begin
      step(8'h01, 8'h00);
      if (i == 5) check("gpio_e5", io_gpio_in, 8'h00);
      if (i == 6) check("rise_e6", io_rise, 8'h01);
      if (i == 7) check("rise_e7", io_rise, 8'h00);
    end

    for (int i = 0; i < 3; i++) step(8'h09, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(8'h01, 8'h00);
      check("glitch_gpio", io_gpio_in, 8'h01);
    end

    step(8'h01, 8'h01);
    check("clear", io_edge_pending, 8'h00);

    for (int i = 1; i <= 8; i++) begin
      step(8'h00, 8'h01);
      if (i == 6) check("fall_e6", io_fall, 8'h01);
      if (i == 6) check("set_wins", io_edge_pending, 8'h01);
      if (i == 7) check("clr_after", io_edge_pending, 8'h00);
    end

    for (int i = 1; i <= 8; i++) begin
      step(8'h81, 8'h00);
      if (i == 6) check("rise_81", io_rise, 8'h81);
      if (i == 6) check("gpio_81", io_gpio_in, 8'h81);
    end

    io_pins_in = 8'hFF;
    assert_reset();
    release_reset(3);
    for (int i = 1; i <= 8; i++) begin
      step(8'hFF, 8'h00);
      if (i == 6) check("rise_ff", io_rise, 8'hFF);
    end

    for (int i = 0; i < 4; i++) step(8'h00, 8'h00);
    assert_reset();
    check("midrst_gpio", io_gpio_in, 8'h00);
    check("midrst_pend", io_edge_pending, 8'h00);
    io_pins_in = 8'h00;
    release_reset(2);

    p = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(5) == 0) p[b] = ~p[b];
      c = ($urandom_range(7) == 0) ? W'($urandom) : '0;
      step(p, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input-side conditioner for the FPGA top's GPIO inputs: the counterpart of the LED output path. Takes raw asynchronous board inputs (switches, buttons, PMOD input pins) and synchronizes them into the `sysclk` domain. Debounces each bit and produces clean levels for `FpgaTop` `io_gpio_in_*`, plus per-bit rise/fall pulses and sticky, software-clearable edge flags. Sits in `Top` between the board pins and the FlexPRET core.

## Interface

Parameters:
- `WIDTH`, 8: number of input bits (8 for `SWS`, 4 for `BTNS`/`JBI`).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronized samples required to accept a new level; legal range ≥ 1 (50000 = 1 ms at 50 MHz).

Ports:
- `clock`  in  1  `sysclk` from `clk_wiz_0`; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; asserts immediately, deassertion is synchronous to `clock` by the top.
- `io_pins_in`  in  WIDTH  raw asynchronous board inputs.
- `io_gpio_in`  out  WIDTH  debounced stable level per bit; reset 0.
- `io_rise`  out  WIDTH  one-cycle pulse when a bit's stable level goes 0→1; reset 0.
- `io_fall`  out  WIDTH  one-cycle pulse when a bit's stable level goes 1→0; reset 0.
- `io_edge_pending`  out  WIDTH  sticky per-bit flag, set by any accepted edge; reset 0.
- `io_clear`  in  WIDTH  write-1-to-clear mask for `io_edge_pending`, sampled each cycle.
- `io_any_pending`  out  1  OR-reduction of `io_edge_pending` (interrupt source); reset 0.

## Operation

- Per bit, two-flop synchronizer: `s1 <= pin`, `s2 <= s1`; both reset to 0.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, reset 0. Each cycle:
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`, and fire `rise` (s2=1) or `fall` (s2=0) for exactly the next cycle.
  - Otherwise: `cnt <= cnt+1`.
- Glitch shorter than `DEBOUNCE_CYCLES` synchronized samples: counter returns to 0, no change, no pulse.
- Pending: `pending <= (pending & ~io_clear) | rise | fall`. Set wins over clear in the same cycle.
- `rise` and `fall` are mutually exclusive per bit. Bits are fully independent.
- Reset with a pin held high: after deassertion the bit is accepted as a normal 0→1 edge. It raises `rise` and `pending`, which software must clear at boot.
- Reset mid-count: counter, stable level, pulses and pending all return to 0 asynchronously.

## Timing

- Pin changes before capture edge E1: `s2` reflects it after E2.
- `io_gpio_in` changes after edge E(`DEBOUNCE_CYCLES`+2) if the pin holds; with `DEBOUNCE_CYCLES`=1, after E3.
- `io_rise`/`io_fall` are high during the same cycle that `io_gpio_in` first shows the new level.
- `io_edge_pending` goes high at that same edge; `io_any_pending` is combinational from pending (same cycle).
- `io_clear` applied at edge E: pending reads 0 after E, unless a new edge is accepted at E.
- Pulses are registered; all outputs come from flops except `io_any_pending`.

## Structure

- Sub-module `debounce_bit`: synchronizer, counter, stable flop and pulse flops for one bit. The top instantiates it WIDTH times in a generate loop and holds the pending register.
- Shared package `gpio_pkg`: default `DEBOUNCE_CYCLES`, a `cnt_width(n)` function, and the `SYNC_STAGES`=2 constant, reused by other pin-facing blocks.

## Test plan

- Reset with pins=0, `DEBOUNCE_CYCLES`=4 → all outputs 0 and stay 0 for 20 cycles.
- Bit 0 to 1 held → `io_gpio_in`=0x01 after edge 6, `io_rise`=0x01 for one cycle, pending=0x01, `io_any_pending`=1.
- Bit 3 high for 3 cycles then low, `DEBOUNCE_CYCLES`=4 → no change on any output.
- `io_clear`=0x01 with pending=0x01 → pending 0x00 next cycle; clear applied on the same edge a fall is accepted → pending remains 1.
- Bits 0 and 7 toggle simultaneously → independent pulses in the same cycle; `io_gpio_in` goes 0x00→0x81.
- Pins=0xFF through reset → `io_rise`=0xFF once after deassertion+6; assert reset mid-count on another run → counters and outputs 0 immediately.
